// File: rtl/twdl_idx_gen_pkg.sv
// twdl_pkg: shared types and constants for the twiddle index sequencer.
//   tw_idx_t  - numerator / denominator / count word
//   state_t   - sequencer FSM states
//   NBR       - numerator lanes (largest radix)
//   BYPASS_L  - denominator value that marks a bypass stage
//   MIN_R/MAX_R - legal radix range
//   cfg_legal - start-time config check
package twdl_pkg;

    typedef logic [11:0] tw_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NBR      = 5;
    localparam int BYPASS_L = 3;
    localparam int MIN_R    = 2;
    localparam int MAX_R    = 5;

    // Inputs are pre-reduced to "is non-zero" flags so the check stays width-agnostic.
    function automatic logic cfg_legal(input logic [2:0] r,
                                       input logic       m_nz,
                                       input logic       g_nz);
        return m_nz && g_nz && (r >= 3'(MIN_R)) && (r <= 3'(MAX_R));
    endfunction

endpackage

// File: rtl/twdl_idx_gen_if.sv
// twdl_idx_gen_if: start/config/step handshake and twiddle outputs of the sequencer.
//   master: drives start, cfg_*, step; observes twiddle outputs and status.
//   slave : the sequencer side.
interface twdl_idx_gen_if #(
    parameter int wIdx = $bits(twdl_pkg::tw_idx_t),
    parameter int NBR  = twdl_pkg::NBR
) ();
    import twdl_pkg::*;

    logic                         start;
    logic [2:0]                   cfg_factor;
    logic [wIdx-1:0]              cfg_m;
    logic [wIdx-1:0]              cfg_ngrp;
    logic [wIdx-1:0]              cfg_demontr;
    logic                         step;
    logic [0:NBR-1][wIdx-1:0]     twdl_numrtr;
    logic [wIdx-1:0]              twdl_demontr;
    logic [2:0]                   factor;
    logic                         tw_val;
    logic                         busy;
    logic                         done;
    logic                         err;

    modport master (
        output start, cfg_factor, cfg_m, cfg_ngrp, cfg_demontr, step,
        input  twdl_numrtr, twdl_demontr, factor, tw_val, busy, done, err
    );

    modport slave (
        input  start, cfg_factor, cfg_m, cfg_ngrp, cfg_demontr, step,
        output twdl_numrtr, twdl_demontr, factor, tw_val, busy, done, err
    );

endinterface

// File: rtl/twdl_idx_gen_wrap_cnt.sv
// twdl_wrap_cnt: enabled down-counter with a programmable terminal count.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - (re)load the counter with term and remember term for later wraps
//   term       - terminal count (number of enabled cycles per wrap minus one)
//   en         - count enable
//   wrap       - high on the enabled cycle that completes a full period
module twdl_wrap_cnt #(
    parameter int W = $bits(twdl_pkg::tw_idx_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] term,
    input  logic         en,
    output logic         wrap
);
    import twdl_pkg::*;

    logic [W-1:0] cnt;
    logic [W-1:0] term_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            term_q <= '0;
        end else if (load) begin
            cnt    <= term;
            term_q <= term;
        end else if (en) begin
            cnt <= (cnt == '0) ? term_q : cnt - W'(1);
        end
    end

    assign wrap = en && (cnt == '0);

endmodule

// File: rtl/twdl_idx_gen.sv
// twdl_idx_gen: twiddle index sequencer for one mixed-radix FFT stage.
// Latches radix/M/G/L on start, then walks butterfly index p (outer) and
// group index g (inner) one position per step, emitting the numerators
// i*p per lane one cycle after each step.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - twdl_idx_gen_if.slave (start/cfg/step in, numerators/status out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a legal start; config outputs hold the last stage
// RUN   | stage in progress, one (p,g) position consumed per step
// DONE  | single cycle after the last step, done pulse
module twdl_idx_gen #(
    parameter int wIdx = $bits(twdl_pkg::tw_idx_t),
    parameter int NBR  = twdl_pkg::NBR
) (
    input  logic           clk,
    input  logic           rst_n,
    twdl_idx_gen_if.slave  bus
);
    import twdl_pkg::*;

    state_t state, state_nxt;

    logic                      cfg_ok;
    logic                      accept;
    logic                      run_step;
    logic                      g_wrap;
    logic                      p_wrap;
    logic                      last_step;
    logic                      bypass;
    logic                      err_set;

    logic [2:0]                factor_q;
    logic [wIdx-1:0]           demontr_q;
    logic [wIdx-1:0]           acc [NBR];
    logic [0:NBR-1][wIdx-1:0]  numrtr_q;
    logic                      tw_val_q;
    logic                      err_q;
    logic                      busy;
    logic                      done;

    assign cfg_ok    = cfg_legal(bus.cfg_factor, bus.cfg_m != '0, bus.cfg_ngrp != '0);
    assign accept    = (state == IDLE) && bus.start && cfg_ok;
    assign run_step  = (state == RUN) && bus.step;
    assign last_step = g_wrap && p_wrap;
    assign bypass    = (demontr_q == wIdx'(BYPASS_L));

    // Ignored starts/steps and rejected configs all flag the sticky error.
    assign err_set = (bus.start && ((state != IDLE) || !cfg_ok))
                   || (bus.step && (state != RUN));

    // g advances every step; p advances only when g wraps.
    twdl_wrap_cnt #(.W(wIdx)) u_g_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .term  (bus.cfg_ngrp - wIdx'(1)),
        .en    (run_step),
        .wrap  (g_wrap)
    );

    twdl_wrap_cnt #(.W(wIdx)) u_p_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .term  (bus.cfg_m - wIdx'(1)),
        .en    (g_wrap),
        .wrap  (p_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            factor_q  <= '0;
            demontr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                factor_q  <= bus.cfg_factor;
                demontr_q <= bus.cfg_demontr;
            end
            err_q <= err_set || (err_q && !accept);
        end
    end

    // acc[i] tracks i*p: add i on every p advance, clear on p wrap.
    // Lanes at or above the radix are never advanced and stay 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBR; i++) acc[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NBR; i++) acc[i] <= '0;
        end else if (g_wrap) begin
            for (int i = 0; i < NBR; i++) begin
                if (p_wrap) begin
                    acc[i] <= '0;
                end else if (i < int'(factor_q)) begin
                    acc[i] <= acc[i] + wIdx'(i);
                end
            end
        end
    end

    // Numerators capture the (p,g) that was current when the step arrived.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            numrtr_q <= '0;
            tw_val_q <= 1'b0;
        end else begin
            tw_val_q <= run_step;
            if (run_step) begin
                for (int i = 0; i < NBR; i++) begin
                    numrtr_q[i] <= bypass ? '0 : acc[i];
                end
            end
        end
    end

    assign bus.twdl_numrtr  = numrtr_q;
    assign bus.twdl_demontr = demontr_q;
    assign bus.factor       = factor_q;
    assign bus.tw_val       = tw_val_q;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.err          = err_q;

endmodule

// File: doc/twdl_idx_gen.md
Name: twdl_idx_gen

Overview:
- Sequencer that drives the twiddle-multiplier stage of the mixed-radix (2/3/4/5) CTA FFT datapath.
- Per butterfly it emits the twiddle numerator vector, the denominator (sub-transform length L) and the radix factor, in lock-step with the butterflies entering the multiplier.
- Config is latched at start; the block then walks the butterfly index p (outer loop) and the group index g (inner loop) for one stage.

Parameters:
- wIdx, 12, width of numerators, denominator, counts.
- NBR, 5, numerator lanes (max radix).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a stage; config sampled this cycle.
- cfg_factor  in  3  radix r, legal 2..5.
- cfg_m  in  wIdx  butterflies per group M = L/r, must be >0.
- cfg_ngrp  in  wIdx  groups G, must be >0.
- cfg_demontr  in  wIdx  denominator L; value 3 = bypass stage.
- step  in  1  one pulse per butterfly accepted downstream.
- twdl_numrtr  out  [0:NBR-1][wIdx]  numerator per branch.
- twdl_demontr  out  wIdx  latched L.
- factor  out  3  latched r.
- tw_val  out  1  numerators valid (registered step).
- busy  out  1  stage in progress.
- done  out  1  one-cycle pulse after last step.
- err  out  1  sticky error flag, cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States:
  - IDLE: start with cfg_m>0, cfg_ngrp>0 and cfg_factor in 2..5 -> RUN. Latches config; p=g=0; all accumulators 0; busy=1 next cycle.
  - IDLE, illegal config on start: stay IDLE, err<=1.
  - RUN: each step advances. g increments; at g==G-1, g->0 and p increments. At p==M-1 and g==G-1 (last step) -> DONE.
  - DONE: one cycle, done=1, busy=0 -> IDLE.
- Output timing: step at cycle t -> tw_val=1 at t+1, with twdl_numrtr holding the values for the (p,g) current at t.
- Between steps, twdl_numrtr holds its last value and tw_val=0.
- Numerators: lane i = i*p for i<r; lane i = 0 for i>=r; lane 0 always 0.
  - Computed incrementally: acc[i] += i on each p increment, cleared on p wrap. No multipliers.
  - i*p <= (r-1)(M-1) < L <= 4095, so no overflow.
- Bypass: cfg_demontr==3 forces all numerators to 0. Counting, tw_val and done behave normally.
- twdl_demontr and factor hold latched values from start until the next accepted start, including through IDLE.
- step in IDLE or DONE: ignored, err<=1.
- start while RUN: ignored, err<=1, counting unaffected.
- Total tw_val pulses per stage = M*G exactly.
- rst_n low mid-RUN: next edge all state and outputs return to reset values. No done is emitted.
- Single-step stage (M=1, G=1): step -> tw_val at t+1, done at t+1, IDLE at t+2.

Decomposition:
- Package twdl_pkg holds:
  - typedef tw_idx_t (logic [11:0]).
  - enum state_t {IDLE, RUN, DONE}.
  - localparam NBR=5, BYPASS_L=3, MIN_R=2, MAX_R=5.
- Sub-module twdl_wrap_cnt: enabled counter with programmable terminal count, wrap pulse output. Instantiated twice, for g (inner) and p (outer, enabled by the g wrap).

Test Plan:
- r=4, M=4, G=2, L=16; 8 steps -> p sequence 0,0,1,1,2,2,3,3. At p=3: lanes [0,3,6,9,0]. done one cycle after 8th step; 8 tw_val pulses.
- r=5, M=3, G=1, L=15; steps with gaps -> lanes at p=2 [0,2,4,6,8]. tw_val only on cycles after each step; values held between steps.
- cfg_demontr=3, r=3, M=2, G=2 -> 4 tw_val pulses, all numerators 0, twdl_demontr=3, done after 4th step.
- start with cfg_m=0, then with cfg_factor=6 -> stays IDLE, err=1, busy=0. Next legal start clears err.
- start pulsed mid-RUN, and step in IDLE -> err=1; stage step count and done timing unchanged.
- rst_n low after 3 of 8 steps -> all outputs 0, no done. Fresh start afterwards replays the full sequence from p=0.
